// File: rtl/serial_sub_cmp.sv
// Bit-serial subtract-and-compare: diff = a - b one bit per cycle (LSB first),
// then registered lt/gt/eq/ovf flags in signed or unsigned mode.
module serial_sub_cmp #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             lt,
   output logic             gt,
   output logic             eq,
   output logic             ovf
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, a_sh_nx;
   logic [WIDTH-1:0] b_sh, b_sh_nx;
   logic [WIDTH-1:0] acc, acc_nx;
   logic             carry, carry_nx;
   logic             mode, mode_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             busy_nx, done_nx;
   logic [WIDTH-1:0] diff_nx;
   logic             lt_nx, gt_nx, eq_nx, ovf_nx;

   // One full-adder slice plus the flag values for the final bit
   logic             b_inv, sum_bit, cout_bit, last_bit;
   logic [WIDTH-1:0] full_diff;
   logic             ovf_bit, lt_bit, eq_bit;

   always_comb begin
      b_inv     = ~b_sh[0];
      sum_bit   = a_sh[0] ^ b_inv ^ carry;
      cout_bit  = (a_sh[0] & b_inv) | (a_sh[0] & carry) | (b_inv & carry);
      full_diff = {sum_bit, acc[WIDTH-1:1]};
      last_bit  = (cnt == CW'(WIDTH - 1));
      // carry currently held is the carry into the MSB when the last bit is processed
      ovf_bit   = carry ^ cout_bit;
      lt_bit    = mode ? (full_diff[WIDTH-1] ^ ovf_bit) : ~cout_bit;
      eq_bit    = (full_diff == '0);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nx = state;
      a_sh_nx  = a_sh;
      b_sh_nx  = b_sh;
      acc_nx   = acc;
      carry_nx = carry;
      mode_nx  = mode;
      cnt_nx   = cnt;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      diff_nx  = diff;
      lt_nx    = lt;
      gt_nx    = gt;
      eq_nx    = eq;
      ovf_nx   = ovf;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = SHIFT;
               a_sh_nx  = a;
               b_sh_nx  = b;
               mode_nx  = signed_mode;
               carry_nx = 1'b1;
               cnt_nx   = '0;
               busy_nx  = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            a_sh_nx  = a_sh >> 1;
            b_sh_nx  = b_sh >> 1;
            acc_nx   = full_diff;
            carry_nx = cout_bit;
            cnt_nx   = cnt + CW'(1);
            if (last_bit) begin
               state_nx = DONE;
               done_nx  = 1'b1;
               diff_nx  = full_diff;
               ovf_nx   = ovf_bit;
               lt_nx    = lt_bit;
               eq_nx    = eq_bit;
               gt_nx    = ~lt_bit & ~eq_bit;
            end else begin
               busy_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         mode  <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         lt    <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         a_sh  <= a_sh_nx;
         b_sh  <= b_sh_nx;
         acc   <= acc_nx;
         carry <= carry_nx;
         mode  <= mode_nx;
         cnt   <= cnt_nx;
         busy  <= busy_nx;
         done  <= done_nx;
         diff  <= diff_nx;
         lt    <= lt_nx;
         gt    <= gt_nx;
         eq    <= eq_nx;
         ovf   <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_serial_sub_cmp.sv
// Directed bench for serial_sub_cmp: hand-computed vectors, timing, hold,
// back-to-back, ignored mid-op start and asynchronous reset.
module tb_serial_sub_cmp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;
   logic        signed_mode;
   logic        busy, done;
   logic [15:0] diff;
   logic        lt, gt, eq, ovf;

   int checks = 0;
   int errors = 0;

   // expected contents of the result registers from the previous completion
   logic [15:0] p_diff  = 16'h0000;
   logic [3:0]  p_flags = 4'b0000;

   serial_sub_cmp #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .signed_mode(signed_mode), .busy(busy), .done(done), .diff(diff),
      .lt(lt), .gt(gt), .eq(eq), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // flags packed as {lt,gt,eq,ovf}
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tm, input logic [15:0] e_diff, input logic [3:0] e_flags,
                        input logic pulse_mid);
      int n;
      int busy_cnt;
      int overlap;
      a = ta; b = tb_v; signed_mode = tm; start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); signed_mode = ~tm;
      chk({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
      busy_cnt = 1; n = 0; overlap = 0;
      while (!done && n < 40) begin
         start = (pulse_mid && n == 4);
         tick();
         n++;
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (n == 8) begin
            chk({tag, "_hold_diff"}, 32'(diff), 32'(p_diff));
            chk({tag, "_hold_flags"}, 32'({lt, gt, eq, ovf}), 32'(p_flags));
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, n, 16);
      chk({tag, "_busy_cycles"}, busy_cnt, 16);
      chk({tag, "_overlap"}, overlap, 0);
      chk({tag, "_diff"}, 32'(diff), 32'(e_diff));
      chk({tag, "_flags"}, 32'({lt, gt, eq, ovf}), 32'(e_flags));
      p_diff = e_diff; p_flags = e_flags;
      tick();
      chk({tag, "_done_pulse"}, 32'({busy, done}), 32'b00);
   endtask

   initial begin
      logic [15:0] bb_a [3];
      logic [15:0] bb_b [3];
      logic        bb_m [3];
      logic [15:0] bb_d [3];
      logic [3:0]  bb_f [3];
      int          n;

      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_outputs", 32'({busy, done, diff, lt, gt, eq, ovf}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      do_op("u_5m3",     16'h0005, 16'h0003, 1'b0, 16'h0002, 4'b0100, 1'b0);
      do_op("s_3m5",     16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b1000, 1'b0);
      do_op("u_3m5",     16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b1000, 1'b0);
      do_op("s_ovf",     16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1001, 1'b0);
      do_op("u_ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0101, 1'b0);
      do_op("eq_1234",   16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0010, 1'b0);
      do_op("u_ffff",    16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 4'b0100, 1'b1);
      do_op("s_7fff_m1", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 4'b0101, 1'b1);

      // back-to-back with start held high
      bb_a[0] = 16'h0000; bb_b[0] = 16'h0001; bb_m[0] = 1'b0; bb_d[0] = 16'hFFFF; bb_f[0] = 4'b1000;
      bb_a[1] = 16'h8000; bb_b[1] = 16'h7FFF; bb_m[1] = 1'b1; bb_d[1] = 16'h0001; bb_f[1] = 4'b1001;
      bb_a[2] = 16'hFFFF; bb_b[2] = 16'hFFFE; bb_m[2] = 1'b1; bb_d[2] = 16'h0001; bb_f[2] = 4'b0100;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = bb_a[i]; b = bb_b[i]; signed_mode = bb_m[i];
         tick();
         chk("b2b_accept", 32'({busy, done}), 32'b10);
         n = 0;
         while (!done && n < 40) begin
            tick();
            n++;
            chk("b2b_busy_or_done", 32'(busy ^ done), 32'd1);
         end
         chk("b2b_latency", n, 16);
         chk("b2b_diff", 32'(diff), 32'(bb_d[i]));
         chk("b2b_flags", 32'({lt, gt, eq, ovf}), 32'(bb_f[i]));
      end
      start = 1'b0;
      tick();
      chk("b2b_idle", 32'({busy, done}), 32'b00);

      // asynchronous reset in the middle of an operation
      a = 16'h00AA; b = 16'h0011; signed_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midop_reset_outputs", 32'({busy, done, diff, lt, gt, eq, ovf}), 32'd0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done || busy) n++;
      end
      chk("reset_no_done", n, 0);
      rst_n = 1'b1;
      p_diff = 16'h0000; p_flags = 4'b0000;
      do_op("eq_7m7", 16'h0007, 16'h0007, 1'b1, 16'h0000, 4'b0010, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
